// File: rtl/mult8_seq.sv
// mult8_seq: sequential 8x8 shift-add multiplier with valid/ready handshakes.
// One operand pair is accepted in IDLE, eight shift-add steps run in BUSY,
// and the 16-bit product is presented in DONE until the consumer takes it.
// Optional build macro: MULT8_SEQ_SIGNED_EN selects two's-complement operands
// (magnitudes are multiplied and the sign is applied on the final step).
module mult8_seq #(
  parameter logic [15:0] RESET_PRODUCT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  count;
  logic [7:0]  a_reg;
  // {C, PH, PL}: carry, high partial product, multiplier / low product bits
  logic [16:0] acc;
  logic [8:0]  sum;
  logic [16:0] acc_step;
  logic [15:0] magnitude;

`ifdef MULT8_SEQ_SIGNED_EN
  logic neg;

  // Magnitude of a two's-complement byte; -128 maps to 8'h80.
  function automatic logic [7:0] abs8(input logic [7:0] x);
    return x[7] ? (8'd0 - x) : x;
  endfunction

  // Apply the result sign to an unsigned 16-bit magnitude.
  function automatic logic [15:0] apply_sign(input logic [15:0] m, input logic s);
    return s ? (16'd0 - m) : m;
  endfunction
`endif

  // Status outputs are decoded from state only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One shift-add step. C is always 0 entering a step (the previous shift
  // cleared it), so adding into {C,PH} is the same as adding into {0,PH}.
  always_comb begin
    sum       = {acc[16], acc[15:8]} + (acc[0] ? {1'b0, a_reg} : 9'd0);
    acc_step  = {1'b0, sum, acc[7:1]};
    magnitude = acc_step[15:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, eight steps in BUSY, release in DONE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (count == 3'd7) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add iteration and product load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 3'd0;
      a_reg   <= 8'd0;
      acc     <= 17'd0;
      product <= RESET_PRODUCT;
`ifdef MULT8_SEQ_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            count <= 3'd0;
`ifdef MULT8_SEQ_SIGNED_EN
            a_reg <= abs8(a);
            acc   <= {9'd0, abs8(b)};
            neg   <= a[7] ^ b[7];
`else
            a_reg <= a;
            acc   <= {9'd0, b};
`endif
          end
        end
        BUSY: begin
          acc   <= acc_step;
          count <= count + 3'd1;
          if (count == 3'd7) begin
`ifdef MULT8_SEQ_SIGNED_EN
            product <= apply_sign(magnitude, neg);
`else
            product <= magnitude;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/mult8_seq.md
MULT8_SEQ -- requirements
Module: mult8_seq

Interface
REQ-001 Parameter RESET_PRODUCT, default 16'h0000, the value loaded into product on reset.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand pair a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  8  multiplicand.
REQ-007 b  input  8  multiplier.
REQ-008 out_valid  output  1  product is valid.
REQ-009 out_ready  input  1  consumer takes the product.
REQ-010 product  output  16  result of a*b.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-012 in_ready SHALL be 1 exactly when in IDLE, and out_valid SHALL be 1 exactly when in DONE.
REQ-013 Accept rule: on a clk edge in IDLE with in_valid=1, the block SHALL latch A=a, load accumulator {C,PH,PL}={1'b0,8'h00,b}, clear the 3-bit count and go to BUSY.
REQ-014 Each BUSY cycle SHALL perform one shift-add step:
  - if PL[0]=1, form {C,PH}=PH+A as a 9-bit sum (8-bit add plus carry-out); otherwise {C,PH}={0,PH};
  - then shift {C,PH,PL} right one bit, with C going to PH[7];
  - then increment the count.
REQ-015 The accumulator SHALL be 17 bits wide so that the carry is never lost.
REQ-016 After the 8th BUSY step (count wraps 7->0), the block SHALL load product={PH,PL} and go to DONE.
REQ-017 Latency: out_valid SHALL rise exactly 8 clk edges after the accepting edge.
REQ-018 Throughput: one operation SHALL complete every 10 cycles minimum.
REQ-019 DONE SHALL hold product and out_valid stable until an edge with out_ready=1, then go to IDLE.
REQ-020 in_ready SHALL be 0 in DONE even when out_ready=1, so that no accept-and-release occurs in the same cycle.
REQ-021 in_valid SHALL be ignored in BUSY and DONE; a, b and in_valid changes during BUSY SHALL have no effect on the result.
REQ-022 product SHALL change only on the transition BUSY->DONE or on reset, and SHALL retain the last result in IDLE.
REQ-023 All state SHALL be registered; outputs SHALL be driven from registers or decoded from state only, with no combinational path from inputs to outputs.

Reset
REQ-024 On rst_n=0, asynchronously and regardless of state, the block SHALL:
  - go to IDLE;
  - clear count, A and the accumulator;
  - set product=RESET_PRODUCT, out_valid=0 and in_ready=1 (immediately after reset).
REQ-025 Reset mid-BUSY or mid-DONE SHALL discard the operation, with no out_valid pulse for it.
REQ-026 On the first edge after rst_n rises, the block SHALL accept an operand pair if in_valid=1.

Configuration
REQ-027 Macro MULT8_SEQ_SIGNED_EN SHALL select between signed and unsigned operation.
REQ-028 With MULT8_SEQ_SIGNED_EN defined, a and b SHALL be two's-complement, and on accept the block SHALL:
  - latch A=|a| and PL=|b| as 8-bit unsigned, so that -128 gives 8'h80;
  - latch neg=a[7]^b[7].
REQ-029 With MULT8_SEQ_SIGNED_EN defined, on BUSY->DONE the block SHALL set product = neg ? -{PH,PL} : {PH,PL} (16-bit two's complement), with no added latency.
REQ-030 Without MULT8_SEQ_SIGNED_EN, a and b SHALL be unsigned, and neither the neg register nor the negation logic SHALL exist.

Verification
REQ-031 Unsigned basic: a=13, b=11, in_valid pulse -> out_valid 8 edges later, product=16'h008F.
REQ-032 Unsigned carry path: a=255, b=255 -> product=16'hFE01; separately a=0, b=200 -> product=16'h0000.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles after DONE -> product and out_valid stay stable and in_ready stays 0; then out_ready=1 for one edge -> IDLE and in_ready=1.
REQ-034 Ignored input: change a/b and pulse in_valid during BUSY -> no effect on the result and no second accept.
REQ-035 Reset mid-operation: assert rst_n=0 at BUSY step 4 -> immediately out_valid=0 and product=RESET_PRODUCT; a new op 7*9 after release -> product=16'h003F.
REQ-036 Signed, MULT8_SEQ_SIGNED_EN defined: a=-3, b=5 -> product=16'hFFF1; a=-128, b=-128 -> product=16'h4000; a=127, b=-128 -> product=16'hC080.
